execution: RTL and testbench
============================

// Module: execution
// PURPOSE
//  EX stage of the 5-stage MIPS-like core; sits between decode (ID) and memory (MEM).
//  Selects ALU operands, executes ALUOp, picks the destination register and computes the branch target.
//  Registers all results plus the MEM/WB control bits into the EX/MEM pipeline register.
// PARAMETERS
//  INST_MEM_WIDTH  2  width of word-addressed PC / instruction-memory index
// PORTS (name  dir  width  meaning)
//  clk  in  1  pipeline clock, all outputs update on rising edge
//  rstn  in  1  asynchronous active-low reset
//  RegWrite / RegWrite_next  in/out  1  register-file write enable, passed through
//  MemtoReg / MemtoReg_next  in/out  2  WB source select, passed through
//  Branch / Branch_next  in/out  2  branch type, passed through (resolved downstream)
//  MemWrite,MemRead / *_next  in/out  1 each  data-memory strobes, passed through
//  UARTtoReg / UARTtoReg_next  in/out  1  UART-receive-to-register, passed through
//  RegtoUART  in  1  reserved; no effect in this stage
//  ALUSrcs  in  2  op2 select
//  ALUSrcs2  in  1  op1 select
//  ALUOp  in  4  ALU operation
//  RegDist  in  2  destination-register select
//  op1_sub, op2_sub  in  32 each  rs / rt register values from ID
//  rt, rd, sa  in  5 each  instruction fields
//  immediate  in  16  instruction immediate
//  inst_index / inst_index_next  in/out  26  jump index, passed through
//  pc, pc1 / pc_next, pc1_next  in/out  INST_MEM_WIDTH  PC and PC+1, passed through
//  register_data  out  32  store data = op2_sub (always rt value, never immediate)
//  alu_result  out  32  ALU result
//  rdist  out  5  destination register number
//  pc2  out  INST_MEM_WIDTH  branch target
// BEHAVIOUR
//  - Latency: exactly 1 cycle; every output is a flop sampling this cycle's inputs; no stall/flush input.
//  - Reset (rstn=0, asynchronous): every output clears to 0 immediately and holds 0 until rstn=1.
//  - Reset asserted mid-operation: in-flight results are discarded; first post-reset edge loads current inputs.
//  - op1: ALUSrcs2=1 -> op1_sub; ALUSrcs2=0 -> {27'b0,sa}.
//  - op2 by ALUSrcs:
//    - 00 -> op2_sub
//    - 01 -> sign-extended immediate
//    - 10 -> zero-extended immediate
//    - 11 -> {immediate,16'h0}
//  - ALUOp, 32-bit, overflow ignored, results wrap mod 2^32:
//    - 0000 ADD (op1+op2)
//    - 0001 SUB (op1-op2)
//    - 0010 AND
//    - 0011 OR
//    - 0100 XOR
//    - 0101 NOR
//    - 0110 SLT (signed, result 1/0)
//    - 0111 SLTU (unsigned, result 1/0)
//    - 1000 SLL (op2<<op1[4:0])
//    - 1001 SRL (logical)
//    - 1010 SRA (arithmetic)
//    - 1011 pass op2
//    - 1100 pass pc1, zero-extended to 32 (link value)
//    - 1101..1111 -> 0
//  - Shift amount uses only op1[4:0]; shift by 0 returns op2 unchanged.
//  - RegDist:
//    - 00 -> rt
//    - 01 -> rd
//    - 10 -> 5'd31 (link)
//    - 11 -> 5'd0
//  - pc2 = pc1 + immediate[INST_MEM_WIDTH-1:0], wrapping modulo 2^INST_MEM_WIDTH.
//  - Control bits are copied unchanged; this stage never gates RegWrite/MemWrite.
// TESTING
//  - Reset: rstn=0 with any inputs -> all outputs 0 without a clock edge; stay 0 until rstn=1.
//  - ADD/SUB: ALUSrcs=00, ALUSrcs2=1, op1_sub=0x1010, op2_sub=0x0101.
//    - ALUOp=0000 -> alu_result=0x00001111 one edge later.
//    - ALUOp=0001 -> 0x00000F0F.
//    - register_data=0x00000101.
//  - Immediate: ALUSrcs=01, immediate=0xFFFC, ADD, op1_sub=0x1010 -> 0x0000100C.
//    - ALUSrcs=10 -> 0x0001100C.
//    - ALUSrcs=11, ALUOp=1011 -> 0xFFFC0000.
//  - Shift/compare: ALUSrcs2=0, sa=4, op2_sub=0x0101.
//    - SLL -> 0x00001010.
//    - op2_sub=0x80000000: SRA -> 0xF8000000; SRL -> 0x08000000.
//    - SLT with op1_sub=0xFFFFFFFF, op2_sub=1 -> 1; SLTU -> 0.
//  - Dest/branch: rt=1, rd=2.
//    - RegDist=00 -> rdist=1; 01 -> 2; 10 -> 31.
//    - pc=1, pc1=2, immediate=0x0001 -> pc2=3; pc1=3 -> pc2=0 (wrap).
//    - inst_index=0x0000001 -> inst_index_next=0x0000001.
//  - Pass-through: toggle each control input alone -> only its *_next changes on the next edge.

Source files
------------

// File: rtl/execution.sv
// ============================================================================
// execution -- EX stage: operand select, ALU, dest-reg select, branch target,
//              all registered into the EX/MEM pipeline register.
// Rev 1.0
// ============================================================================
`default_nettype none

module execution #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rstn,

  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic                      RegtoUART,

  input  logic [1:0]                ALUSrcs,
  input  logic                      ALUSrcs2,
  input  logic [3:0]                ALUOp,
  input  logic [1:0]                RegDist,

  input  logic [31:0]               op1_sub,
  input  logic [31:0]               op2_sub,
  input  logic [4:0]                rt,
  input  logic [4:0]                rd,
  input  logic [4:0]                sa,
  input  logic [15:0]               immediate,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,

  output logic                      RegWrite_next,
  output logic [1:0]                MemtoReg_next,
  output logic [1:0]                Branch_next,
  output logic                      MemWrite_next,
  output logic                      MemRead_next,
  output logic                      UARTtoReg_next,
  output logic [25:0]               inst_index_next,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic [31:0]               register_data,
  output logic [31:0]               alu_result,
  output logic [4:0]                rdist,
  output logic [INST_MEM_WIDTH-1:0] pc2
);

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b0001;
  localparam logic [3:0] c_ALU_AND  = 4'b0010;
  localparam logic [3:0] c_ALU_OR   = 4'b0011;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_NOR  = 4'b0101;
  localparam logic [3:0] c_ALU_SLT  = 4'b0110;
  localparam logic [3:0] c_ALU_SLTU = 4'b0111;
  localparam logic [3:0] c_ALU_SLL  = 4'b1000;
  localparam logic [3:0] c_ALU_SRL  = 4'b1001;
  localparam logic [3:0] c_ALU_SRA  = 4'b1010;
  localparam logic [3:0] c_ALU_OP2  = 4'b1011;
  localparam logic [3:0] c_ALU_LINK = 4'b1100;

  localparam logic [1:0] c_OP2_REG  = 2'b00;
  localparam logic [1:0] c_OP2_SEXT = 2'b01;
  localparam logic [1:0] c_OP2_ZEXT = 2'b10;
  localparam logic [1:0] c_OP2_LUI  = 2'b11;

  localparam logic [1:0] c_DST_RT   = 2'b00;
  localparam logic [1:0] c_DST_RD   = 2'b01;
  localparam logic [1:0] c_DST_LINK = 2'b10;

  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic [31:0] w_link;

  logic [31:0]               alu_result_d;
  logic [4:0]                rdist_d;
  logic [INST_MEM_WIDTH-1:0] pc2_d;

  logic                      RegWrite_q;
  logic [1:0]                MemtoReg_q;
  logic [1:0]                Branch_q;
  logic                      MemWrite_q;
  logic                      MemRead_q;
  logic                      UARTtoReg_q;
  logic [25:0]               inst_index_q;
  logic [INST_MEM_WIDTH-1:0] pc_q;
  logic [INST_MEM_WIDTH-1:0] pc1_q;
  logic [31:0]               register_data_q;
  logic [31:0]               alu_result_q;
  logic [4:0]                rdist_q;
  logic [INST_MEM_WIDTH-1:0] pc2_q;

  // RegtoUART is consumed by a later stage; keep it visibly tied off here.
  logic unused_regtouart;
  assign unused_regtouart = RegtoUART;

  assign w_op1   = ALUSrcs2 ? op1_sub : {27'b0, sa};
  assign w_shamt = w_op1[4:0];
  assign w_link  = {{(32-INST_MEM_WIDTH){1'b0}}, pc1};

  always_comb begin
    w_op2 = op2_sub;
    case (ALUSrcs)
      c_OP2_REG:  w_op2 = op2_sub;
      c_OP2_SEXT: w_op2 = {{16{immediate[15]}}, immediate};
      c_OP2_ZEXT: w_op2 = {16'h0000, immediate};
      c_OP2_LUI:  w_op2 = {immediate, 16'h0000};
      default:    w_op2 = op2_sub;
    endcase
  end

  always_comb begin
    alu_result_d = 32'h0;
    case (ALUOp)
      c_ALU_ADD:  alu_result_d = w_op1 + w_op2;
      c_ALU_SUB:  alu_result_d = w_op1 - w_op2;
      c_ALU_AND:  alu_result_d = w_op1 & w_op2;
      c_ALU_OR:   alu_result_d = w_op1 | w_op2;
      c_ALU_XOR:  alu_result_d = w_op1 ^ w_op2;
      c_ALU_NOR:  alu_result_d = ~(w_op1 | w_op2);
      c_ALU_SLT:  alu_result_d = {31'b0, ($signed(w_op1) < $signed(w_op2))};
      c_ALU_SLTU: alu_result_d = {31'b0, (w_op1 < w_op2)};
      c_ALU_SLL:  alu_result_d = w_op2 << w_shamt;
      c_ALU_SRL:  alu_result_d = w_op2 >> w_shamt;
      c_ALU_SRA:  alu_result_d = $unsigned($signed(w_op2) >>> w_shamt);
      c_ALU_OP2:  alu_result_d = w_op2;
      c_ALU_LINK: alu_result_d = w_link;
      default:    alu_result_d = 32'h0;
    endcase
  end

  always_comb begin
    rdist_d = 5'd0;
    case (RegDist)
      c_DST_RT:   rdist_d = rt;
      c_DST_RD:   rdist_d = rd;
      c_DST_LINK: rdist_d = 5'd31;
      default:    rdist_d = 5'd0;
    endcase
  end

  // Target wraps naturally in the narrow instruction-memory index space.
  assign pc2_d = pc1 + immediate[INST_MEM_WIDTH-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      RegWrite_q      <= 1'b0;
      MemtoReg_q      <= 2'b0;
      Branch_q        <= 2'b0;
      MemWrite_q      <= 1'b0;
      MemRead_q       <= 1'b0;
      UARTtoReg_q     <= 1'b0;
      inst_index_q    <= 26'b0;
      pc_q            <= '0;
      pc1_q           <= '0;
      register_data_q <= 32'h0;
      alu_result_q    <= 32'h0;
      rdist_q         <= 5'd0;
      pc2_q           <= '0;
    end else begin
      RegWrite_q      <= RegWrite;
      MemtoReg_q      <= MemtoReg;
      Branch_q        <= Branch;
      MemWrite_q      <= MemWrite;
      MemRead_q       <= MemRead;
      UARTtoReg_q     <= UARTtoReg;
      inst_index_q    <= inst_index;
      pc_q            <= pc;
      pc1_q           <= pc1;
      register_data_q <= op2_sub;
      alu_result_q    <= alu_result_d;
      rdist_q         <= rdist_d;
      pc2_q           <= pc2_d;
    end
  end

  assign RegWrite_next   = RegWrite_q;
  assign MemtoReg_next   = MemtoReg_q;
  assign Branch_next     = Branch_q;
  assign MemWrite_next   = MemWrite_q;
  assign MemRead_next    = MemRead_q;
  assign UARTtoReg_next  = UARTtoReg_q;
  assign inst_index_next = inst_index_q;
  assign pc_next         = pc_q;
  assign pc1_next        = pc1_q;
  assign register_data   = register_data_q;
  assign alu_result      = alu_result_q;
  assign rdist           = rdist_q;
  assign pc2             = pc2_q;

endmodule

`default_nettype wire

// File: tb/tb_execution.sv
// ============================================================================
// tb_execution -- directed + randomized checks of the EX stage against a
//                 behavioural model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_execution;

  localparam int W = 2;

  typedef struct {
    logic          RegWrite;
    logic [1:0]    MemtoReg;
    logic [1:0]    Branch;
    logic          MemWrite;
    logic          MemRead;
    logic          UARTtoReg;
    logic          RegtoUART;
    logic [1:0]    ALUSrcs;
    logic          ALUSrcs2;
    logic [3:0]    ALUOp;
    logic [1:0]    RegDist;
    logic [31:0]   op1_sub;
    logic [31:0]   op2_sub;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    sa;
    logic [15:0]   immediate;
    logic [25:0]   inst_index;
    logic [W-1:0]  pc;
    logic [W-1:0]  pc1;
  } in_t;

  typedef struct {
    logic          RegWrite;
    logic [1:0]    MemtoReg;
    logic [1:0]    Branch;
    logic          MemWrite;
    logic          MemRead;
    logic          UARTtoReg;
    logic [25:0]   inst_index;
    logic [W-1:0]  pc;
    logic [W-1:0]  pc1;
    logic [31:0]   register_data;
    logic [31:0]   alu_result;
    logic [4:0]    rdist;
    logic [W-1:0]  pc2;
  } out_t;

  logic clk;
  logic rstn;
  in_t  cur;

  logic          RegWrite_next, MemWrite_next, MemRead_next, UARTtoReg_next;
  logic [1:0]    MemtoReg_next, Branch_next;
  logic [25:0]   inst_index_next;
  logic [W-1:0]  pc_next, pc1_next, pc2;
  logic [31:0]   register_data, alu_result;
  logic [4:0]    rdist;

  int n_checks;
  int n_fail;

  execution #(.INST_MEM_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn),
    .RegWrite(cur.RegWrite), .MemtoReg(cur.MemtoReg), .Branch(cur.Branch),
    .MemWrite(cur.MemWrite), .MemRead(cur.MemRead), .UARTtoReg(cur.UARTtoReg),
    .RegtoUART(cur.RegtoUART), .ALUSrcs(cur.ALUSrcs), .ALUSrcs2(cur.ALUSrcs2),
    .ALUOp(cur.ALUOp), .RegDist(cur.RegDist), .op1_sub(cur.op1_sub),
    .op2_sub(cur.op2_sub), .rt(cur.rt), .rd(cur.rd), .sa(cur.sa),
    .immediate(cur.immediate), .inst_index(cur.inst_index), .pc(cur.pc),
    .pc1(cur.pc1),
    .RegWrite_next(RegWrite_next), .MemtoReg_next(MemtoReg_next),
    .Branch_next(Branch_next), .MemWrite_next(MemWrite_next),
    .MemRead_next(MemRead_next), .UARTtoReg_next(UARTtoReg_next),
    .inst_index_next(inst_index_next), .pc_next(pc_next), .pc1_next(pc1_next),
    .register_data(register_data), .alu_result(alu_result), .rdist(rdist),
    .pc2(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: arithmetic straight from the instruction semantics.
  function automatic out_t model(input in_t s);
    out_t        o;
    logic [31:0] a, b;
    longint      sa_l, sb_l, p2;
    int          sh;
    a  = s.ALUSrcs2 ? s.op1_sub : 32'(s.sa);
    case (s.ALUSrcs)
      2'd0:    b = s.op2_sub;
      2'd1:    b = 32'(longint'($signed(s.immediate)));
      2'd2:    b = 32'(s.immediate);
      default: b = 32'(s.immediate) * 32'd65536;
    endcase
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    sh   = int'(a % 32);
    p2   = longint'(1) << sh;
    o.alu_result = 32'h0;
    case (s.ALUOp)
      4'd0:  o.alu_result = 32'((longint'(a) + longint'(b)) % (longint'(1) << 32));
      4'd1:  o.alu_result = 32'((longint'(a) - longint'(b) + (longint'(1) << 32)) % (longint'(1) << 32));
      4'd2:  o.alu_result = a & b;
      4'd3:  o.alu_result = a | b;
      4'd4:  o.alu_result = a ^ b;
      4'd5:  o.alu_result = ~(a | b);
      4'd6:  o.alu_result = (sa_l < sb_l) ? 32'd1 : 32'd0;
      4'd7:  o.alu_result = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd8:  o.alu_result = 32'((longint'(b) * p2) % (longint'(1) << 32));
      4'd9:  o.alu_result = 32'(longint'(b) / p2);
      4'd10: o.alu_result = 32'((sb_l >= 0) ? (sb_l / p2) : ((sb_l - (p2 - 1)) / p2));
      4'd11: o.alu_result = b;
      4'd12: o.alu_result = 32'(s.pc1);
      default: o.alu_result = 32'h0;
    endcase
    case (s.RegDist)
      2'd0:    o.rdist = s.rt;
      2'd1:    o.rdist = s.rd;
      2'd2:    o.rdist = 5'd31;
      default: o.rdist = 5'd0;
    endcase
    o.pc2           = W'((int'(s.pc1) + int'(s.immediate)) % (1 << W));
    o.register_data = s.op2_sub;
    o.RegWrite      = s.RegWrite;
    o.MemtoReg      = s.MemtoReg;
    o.Branch        = s.Branch;
    o.MemWrite      = s.MemWrite;
    o.MemRead       = s.MemRead;
    o.UARTtoReg     = s.UARTtoReg;
    o.inst_index    = s.inst_index;
    o.pc            = s.pc;
    o.pc1           = s.pc1;
    return o;
  endfunction

  function automatic out_t zero_out();
    out_t z;
    z = model('{default: '0});
    z.alu_result = 32'h0;
    z.rdist      = 5'd0;
    z.pc2        = '0;
    return z;
  endfunction

  task automatic check_all(input string tag, input out_t e);
    check({tag, ".RegWrite"},   32'(RegWrite_next),   32'(e.RegWrite));
    check({tag, ".MemtoReg"},   32'(MemtoReg_next),   32'(e.MemtoReg));
    check({tag, ".Branch"},     32'(Branch_next),     32'(e.Branch));
    check({tag, ".MemWrite"},   32'(MemWrite_next),   32'(e.MemWrite));
    check({tag, ".MemRead"},    32'(MemRead_next),    32'(e.MemRead));
    check({tag, ".UARTtoReg"},  32'(UARTtoReg_next),  32'(e.UARTtoReg));
    check({tag, ".inst_index"}, 32'(inst_index_next), 32'(e.inst_index));
    check({tag, ".pc"},         32'(pc_next),         32'(e.pc));
    check({tag, ".pc1"},        32'(pc1_next),        32'(e.pc1));
    check({tag, ".reg_data"},   register_data,        e.register_data);
    check({tag, ".alu"},        alu_result,           e.alu_result);
    check({tag, ".rdist"},      32'(rdist),           32'(e.rdist));
    check({tag, ".pc2"},        32'(pc2),             32'(e.pc2));
  endtask

  // Apply cur for one edge and compare everything against the model.
  task automatic step(input string tag);
    out_t e;
    e = model(cur);
    @(posedge clk);
    #1;
    check_all(tag, e);
  endtask

  function automatic in_t rand_in();
    in_t s;
    s.RegWrite   = 1'($urandom);
    s.MemtoReg   = 2'($urandom);
    s.Branch     = 2'($urandom);
    s.MemWrite   = 1'($urandom);
    s.MemRead    = 1'($urandom);
    s.UARTtoReg  = 1'($urandom);
    s.RegtoUART  = 1'($urandom);
    s.ALUSrcs    = 2'($urandom);
    s.ALUSrcs2   = 1'($urandom);
    s.ALUOp      = 4'($urandom_range(0, 15));
    s.RegDist    = 2'($urandom);
    s.op1_sub    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    s.op2_sub    = $urandom;
    s.rt         = 5'($urandom);
    s.rd         = 5'($urandom);
    s.sa         = 5'($urandom);
    s.immediate  = 16'($urandom);
    s.inst_index = 26'($urandom);
    s.pc         = W'($urandom);
    s.pc1        = W'($urandom);
    return s;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    cur      = rand_in();

    // Reset holds outputs at zero regardless of inputs and clock edges.
    #2;
    check_all("rst_noedge", zero_out());
    repeat (2) @(posedge clk);
    #1;
    cur = rand_in();
    check_all("rst_hold", zero_out());
    #2;
    rstn = 1'b1;
    #1;
    check_all("rst_release", zero_out());

    // ADD / SUB with register operands.
    cur = '{default: '0};
    cur.ALUSrcs2 = 1'b1;
    cur.op1_sub  = 32'h1010;
    cur.op2_sub  = 32'h0101;
    cur.ALUOp    = 4'b0000;
    step("add");
    check("add.const", alu_result, 32'h0000_1111);
    check("add.regdata", register_data, 32'h0000_0101);
    cur.ALUOp = 4'b0001;
    step("sub");
    check("sub.const", alu_result, 32'h0000_0F0F);

    // Immediate forms.
    cur.immediate = 16'hFFFC;
    cur.ALUSrcs   = 2'b01;
    cur.ALUOp     = 4'b0000;
    step("imm_sext");
    check("imm_sext.const", alu_result, 32'h0000_100C);
    cur.ALUSrcs = 2'b10;
    step("imm_zext");
    check("imm_zext.const", alu_result, 32'h0001_100C);
    cur.ALUSrcs = 2'b11;
    cur.ALUOp   = 4'b1011;
    step("imm_lui");
    check("imm_lui.const", alu_result, 32'hFFFC_0000);
    check("imm_lui.regdata", register_data, 32'h0000_0101);

    // Shifts by sa, compares.
    cur = '{default: '0};
    cur.sa      = 5'd4;
    cur.op2_sub = 32'h0101;
    cur.ALUOp   = 4'b1000;
    step("sll");
    check("sll.const", alu_result, 32'h0000_1010);
    cur.op2_sub = 32'h8000_0000;
    cur.ALUOp   = 4'b1010;
    step("sra");
    check("sra.const", alu_result, 32'hF800_0000);
    cur.ALUOp = 4'b1001;
    step("srl");
    check("srl.const", alu_result, 32'h0800_0000);
    cur.sa    = 5'd0;
    cur.ALUOp = 4'b1010;
    step("sra0");
    check("sra0.const", alu_result, 32'h8000_0000);
    cur.ALUSrcs2 = 1'b1;
    cur.op1_sub  = 32'hFFFF_FFFF;
    cur.op2_sub  = 32'h1;
    cur.ALUOp    = 4'b0110;
    step("slt");
    check("slt.const", alu_result, 32'h1);
    cur.ALUOp = 4'b0111;
    step("sltu");
    check("sltu.const", alu_result, 32'h0);

    // Destination select, branch target and its wrap.
    cur = '{default: '0};
    cur.rt = 5'd1;
    cur.rd = 5'd2;
    for (int i = 0; i < 4; i++) begin
      cur.RegDist = 2'(i);
      step("rdist");
    end
    check("rdist.zero", 32'(rdist), 32'd0);
    cur.pc         = 2'd1;
    cur.pc1        = 2'd2;
    cur.immediate  = 16'h0001;
    cur.inst_index = 26'h000_0001;
    cur.ALUOp      = 4'b1100;
    step("pc2");
    check("pc2.const", 32'(pc2), 32'd3);
    check("link.const", alu_result, 32'd2);
    check("inst_index.const", 32'(inst_index_next), 32'd1);
    cur.pc1 = 2'd3;
    step("pc2wrap");
    check("pc2wrap.const", 32'(pc2), 32'd0);

    // Each control bit toggled alone.
    cur.RegWrite = 1'b1;  step("tog_regwrite");
    cur.MemtoReg = 2'b10; step("tog_memtoreg");
    cur.Branch   = 2'b01; step("tog_branch");
    cur.MemWrite = 1'b1;  step("tog_memwrite");
    cur.MemRead  = 1'b1;  step("tog_memread");
    cur.UARTtoReg = 1'b1; step("tog_uarttoreg");
    cur.RegtoUART = 1'b1; step("tog_regtouart");

    // Randomized traffic with occasional mid-operation reset.
    for (int n = 0; n < 400; n++) begin
      cur = rand_in();
      if (n % 97 == 50) begin
        rstn = 1'b0;
        #1;
        check_all("midrst", zero_out());
        @(posedge clk);
        #1;
        check_all("midrst_hold", zero_out());
        #2;
        rstn = 1'b1;
        cur = rand_in();
        step("midrst_first");
      end else begin
        step("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
